// File: rtl/tage_pkg.sv
// Shared definitions for the TAGE speculative global-history slice.
// Holds the default geometry of the history unit, the per-table history
// lengths used for folding, the checkpoint id type, and a helper that
// returns a legal history length for any table index.
package tage_pkg;

  localparam int TAGE_HIST_LEN   = 64;
  localparam int TAGE_NUM_TABLES = 4;
  localparam int TAGE_FOLD_W     = 10;
  localparam int TAGE_CKPT_DEPTH = 8;

  // Geometric history lengths, shortest table first.
  localparam int TAGE_HIST_LENS [TAGE_NUM_TABLES] = '{8, 20, 40, 64};

  typedef logic [$clog2(TAGE_CKPT_DEPTH)-1:0] ckpt_id_t;

  // History length for table idx, clamped to the available history.
  // Tables beyond the default list use the full history.
  function automatic int table_hist_len(input int idx, input int hist_len);
    int len;
    if (idx < TAGE_NUM_TABLES) len = TAGE_HIST_LENS[idx];
    else                       len = hist_len;
    if (len > hist_len) len = hist_len;
    if (len < 1)        len = 1;
    return len;
  endfunction

endpackage

// File: rtl/tage_hist_fold.sv
// Folds the newest L bits of a global history into FOLD_W bits by XORing
// consecutive FOLD_W-bit chunks together; the last chunk is zero-padded.
// Ports:
//   hist  in  HIST_LEN  history, bit 0 newest
//   fold  out FOLD_W    folded history
module tage_hist_fold #(
  parameter int L        = 8,
  parameter int FOLD_W   = 10,
  parameter int HIST_LEN = 64
) (
  input  logic [HIST_LEN-1:0] hist,
  output logic [FOLD_W-1:0]   fold
);

  localparam int NCHUNK = (L + FOLD_W - 1) / FOLD_W;
  localparam int PAD_W  = NCHUNK * FOLD_W;

  logic [PAD_W-1:0] padded;

  generate
    if (PAD_W > L) begin : g_pad
      assign padded = {{(PAD_W - L){1'b0}}, hist[L-1:0]};
    end else begin : g_nopad
      assign padded = hist[L-1:0];
    end

    // History bits older than L do not participate in this table's fold.
    if (L < HIST_LEN) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^hist[HIST_LEN-1:L];
    end
  endgenerate

  always_comb begin
    fold = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      fold = fold ^ padded[k*FOLD_W +: FOLD_W];
    end
  end

endmodule

// File: rtl/tage_spec_ghr.sv
// Speculative global-history unit for the TAGE predictor.
// Keeps a speculative history (shifted at prediction) and an architectural
// history (shifted at commit), a circular buffer of history checkpoints for
// misprediction repair, and one folded history per tagged table.
// Ports:
//   clk, rst (async, active low)
//   pred_valid/pred_taken         prediction issue; pred_ckpt_id = slot used
//   ckpt_full, ckpt_count         checkpoint occupancy
//   commit_valid/commit_taken     oldest branch retires
//   flush_valid/flush_id/flush_taken  repair from a checkpoint
//   recover_arch                  restore speculative from architectural history
//   spec_ghr, arch_ghr, fold_hist history outputs
module tage_spec_ghr
  import tage_pkg::*;
#(
  parameter int HIST_LEN   = TAGE_HIST_LEN,
  parameter int NUM_TABLES = TAGE_NUM_TABLES,
  parameter int FOLD_W     = TAGE_FOLD_W,
  parameter int CKPT_DEPTH = TAGE_CKPT_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pred_valid,
  input  logic                           pred_taken,
  output logic [$clog2(CKPT_DEPTH)-1:0]  pred_ckpt_id,
  output logic                           ckpt_full,
  input  logic                           commit_valid,
  input  logic                           commit_taken,
  input  logic                           flush_valid,
  input  logic [$clog2(CKPT_DEPTH)-1:0]  flush_id,
  input  logic                           flush_taken,
  input  logic                           recover_arch,
  output logic [HIST_LEN-1:0]            spec_ghr,
  output logic [HIST_LEN-1:0]            arch_ghr,
  output logic [NUM_TABLES*FOLD_W-1:0]   fold_hist,
  output logic [$clog2(CKPT_DEPTH):0]    ckpt_count
);

  localparam int ID_W  = $clog2(CKPT_DEPTH);
  localparam int CNT_W = ID_W + 1;

  logic [HIST_LEN-1:0] spec_ghr_reg, spec_ghr_next;
  logic [HIST_LEN-1:0] arch_ghr_reg, arch_ghr_next;
  logic [ID_W-1:0]     head_reg, head_next;
  logic [ID_W-1:0]     tail_reg, tail_next;
  logic [CNT_W-1:0]    count_reg, count_next;

  logic [HIST_LEN-1:0] ckpt_mem [CKPT_DEPTH];

  logic                full;
  logic                commit_fire;
  logic                pred_fire;
  logic [ID_W-1:0]     head_commit;
  logic [ID_W-1:0]     flush_span;
  logic [HIST_LEN-1:0] flush_ckpt;

  assign full        = (count_reg == CNT_W'(CKPT_DEPTH));
  assign commit_fire = commit_valid && (count_reg != '0);
  assign head_commit = head_reg + ID_W'(commit_fire);
  // Live span after repair, modulo depth; computed at id width so it wraps.
  assign flush_span  = flush_id - head_commit + ID_W'(1);
  assign flush_ckpt  = ckpt_mem[flush_id];
  // A full buffer rejects the prediction even if a commit frees a slot now.
  assign pred_fire   = pred_valid && !full && !flush_valid && !recover_arch;

  always_comb begin
    arch_ghr_next = arch_ghr_reg;
    spec_ghr_next = spec_ghr_reg;
    head_next     = head_commit;
    tail_next     = tail_reg;
    count_next    = count_reg;

    if (commit_fire) begin
      arch_ghr_next = {arch_ghr_reg[HIST_LEN-2:0], commit_taken};
    end

    if (recover_arch) begin
      // Restore from committed history including this cycle's commit.
      spec_ghr_next = arch_ghr_next;
      head_next     = tail_reg;
      count_next    = '0;
    end else if (flush_valid) begin
      spec_ghr_next = {flush_ckpt[HIST_LEN-2:0], flush_taken};
      tail_next     = flush_id + ID_W'(1);
      count_next    = {1'b0, flush_span};
    end else begin
      if (pred_fire) begin
        spec_ghr_next = {spec_ghr_reg[HIST_LEN-2:0], pred_taken};
        tail_next     = tail_reg + ID_W'(1);
      end
      count_next = count_reg + CNT_W'(pred_fire) - CNT_W'(commit_fire);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_ghr_reg <= '0;
      arch_ghr_reg <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
    end else begin
      spec_ghr_reg <= spec_ghr_next;
      arch_ghr_reg <= arch_ghr_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
    end
  end

  // Checkpoint storage holds the pre-shift speculative history; no reset.
  always_ff @(posedge clk) begin
    if (pred_fire) begin
      ckpt_mem[tail_reg] <= spec_ghr_reg;
    end
  end

  assign spec_ghr     = spec_ghr_reg;
  assign arch_ghr     = arch_ghr_reg;
  assign pred_ckpt_id = tail_reg;
  assign ckpt_full    = full;
  assign ckpt_count   = count_reg;

  generate
    for (genvar gi = 0; gi < NUM_TABLES; gi++) begin : g_fold
      tage_hist_fold #(
        .L        (table_hist_len(gi, HIST_LEN)),
        .FOLD_W   (FOLD_W),
        .HIST_LEN (HIST_LEN)
      ) u_fold (
        .hist (spec_ghr_reg),
        .fold (fold_hist[gi*FOLD_W +: FOLD_W])
      );
    end
  endgenerate

endmodule

// File: doc/tage_spec_ghr.md
Name: tage_spec_ghr

Overview:
- Parametrised speculative global-history unit for the TAGE predictor.
- Replaces the single fixed-width, commit-updated GHR with two registers: a speculative history updated at prediction time and an architectural history updated at commit.
- Provides a circular checkpoint buffer for misprediction repair and per-table folded histories for indexing the tagged tables.
- Sits in the TAGE top level between fetch/predict, branch resolution and the tagged tables.

Parameters:
- HIST_LEN, 64: width of the speculative and architectural history registers; bit 0 is the newest outcome.
- NUM_TABLES, 4: number of tagged tables that receive a folded history.
- FOLD_W, 10: width of each folded history.
- CKPT_DEPTH, 8: number of checkpoint entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- pred_valid  in  1  a predicted branch is issued.
- pred_taken  in  1  predicted direction.
- pred_ckpt_id  out  $clog2(CKPT_DEPTH)  checkpoint id allocated to the current prediction.
- ckpt_full  out  1  all checkpoints are in use.
- commit_valid  in  1  the oldest in-flight branch retires.
- commit_taken  in  1  actual direction of the retiring branch.
- flush_valid  in  1  mispredict repair request.
- flush_id  in  $clog2(CKPT_DEPTH)  checkpoint of the mispredicted branch.
- flush_taken  in  1  actual direction of the mispredicted branch.
- recover_arch  in  1  full recovery (exception or interrupt).
- spec_ghr  out  HIST_LEN  speculative history.
- arch_ghr  out  HIST_LEN  committed history.
- fold_hist  out  NUM_TABLES*FOLD_W  folded histories; table i occupies slice [i*FOLD_W +: FOLD_W].
- ckpt_count  out  $clog2(CKPT_DEPTH)+1  number of live checkpoints.

Behaviour:
- Reset (rst=0, asynchronous): spec_ghr=0, arch_ghr=0, head=0, tail=0, ckpt_count=0, ckpt_full=0, pred_ckpt_id=0. Reset takes effect immediately, including mid-operation. Checkpoint storage contents need not be reset.
- State is registered; updates appear one cycle after the input event.
- pred_ckpt_id = tail, driven combinationally from the register.
- ckpt_full = (ckpt_count == CKPT_DEPTH).
- Prediction (pred_valid, !ckpt_full, no flush or recover that cycle):
  - ckpt[tail] <= spec_ghr (the pre-shift value).
  - spec_ghr <= {spec_ghr[HIST_LEN-2:0], pred_taken}.
  - tail <= tail+1, wrapping mod CKPT_DEPTH.
  - count increments.
- Prediction while full: ignored; no state change. A commit in the same cycle does not free a slot for it.
- Commit (commit_valid, count>0):
  - arch_ghr <= {arch_ghr[HIST_LEN-2:0], commit_taken}.
  - head <= head+1, wrapping.
  - Commit with count==0 is ignored entirely, including arch_ghr.
- Flush (flush_valid; flush_id must be live, otherwise behaviour is unspecified):
  - spec_ghr <= {ckpt[flush_id][HIST_LEN-2:0], flush_taken}.
  - tail <= flush_id+1. All younger checkpoints are freed; checkpoint flush_id stays live.
  - count <= (flush_id - head_next + 1) mod CKPT_DEPTH, where head_next already includes any same-cycle commit.
  - If flush_id == head and a commit occurs in the same cycle, count becomes 0.
- Priority, highest first:
  - recover_arch: spec_ghr <= arch_ghr (arch_ghr after any same-cycle commit); head = tail; count = 0; no prediction is taken.
  - flush: takes effect, and any same-cycle prediction is dropped.
  - Commit is applied concurrently with both recover_arch and flush.
- Folded history, per table i with history length L_i (L_i ≤ HIST_LEN):
  - Purely combinational from spec_ghr.
  - fold_i = XOR over k of spec_ghr[L_i-1:0][k*FOLD_W +: FOLD_W]; the final chunk is zero-padded above bit L_i-1.

Decomposition:
- tage_pkg holds:
  - TAGE_HIST_LENS: constant array of L_i, with geometric defaults 8, 20, 40, 64.
  - ckpt_id_t typedef.
  - Default parameter constants.
- One sub-module, tage_hist_fold (parameters L, FOLD_W, HIST_LEN), instantiated NUM_TABLES times in a generate loop.

Test Plan:
- Reset: drive rst=0 mid-sequence with count=3 → spec_ghr, arch_ghr, ckpt_count and pred_ckpt_id all read 0 before the next clock edge.
- Predictions T, T, N from reset → spec_ghr[2:0]=3'b110, ids issued 0, 1, 2, ckpt_count=3.
- Flush repair: after T, T, N, flush_id=1 with flush_taken=0 → spec_ghr[2:0]=3'b010, ckpt_count=2, next pred_ckpt_id=2.
- Full and wrap:
  - 8 predictions → ckpt_full=1; a 9th prediction is ignored and spec_ghr is unchanged.
  - 3 commits, then 3 predictions → ids issued 0, 1, 2 after wrapping past id 7.
- Folding, for table 1 (L=20, FOLD_W=10):
  - spec_ghr[19:0]=20'hFFFFF → fold=10'h000.
  - Only bit 0 set → fold=10'h001.
  - Only bit 19 set → fold=10'h200.
- recover_arch: commit T, N, then 3 further predictions, then recover_arch → spec_ghr[1:0]=2'b10 equals arch_ghr, ckpt_count=0.
